// File: rtl/seven_seg_capture.sv
// seven_seg_capture: samples a scanned active-low 7-segment bus, waits for a
// stable dwell on each single-anode digit, decodes the glyph back to a hex
// nibble and keeps the eight recovered digits with valid/error flags.
// Optional macro SEG_CAPTURE_TIMEOUT_EN builds the stale-scan watchdog.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  segments,
  input  logic [7:0]  anodos,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic [7:0]  digit_err,
  output logic        overlap,
  output logic        frame_done,
  output logic        stale
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

  logic [6:0]    r_pat;
  logic [7:0]    r_sel;
  logic [6:0]    r_last_pat;
  logic [7:0]    r_last_sel;
  logic [SW-1:0] r_stab;
  logic          r_committed;
  logic [31:0]   r_digits;
  logic [7:0]    r_valid, r_err, r_seen;
  logic          r_overlap, r_frame;

  logic          w_single, w_multi, w_same, w_commit, w_expire;
  logic [SW-1:0] w_stab_nxt;
  logic [2:0]    w_idx;
  logic [3:0]    w_nib;
  logic          w_legal;
  logic [7:0]    w_seen_nxt;

  // register the bus once and flip it to active-high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pat <= '0;
      r_sel <= '0;
    end else begin
      r_pat <= ~segments;
      r_sel <= ~anodos;
    end
  end

  // classify the registered sample and work out the next dwell count
  always_comb begin
    w_single   = (r_sel != 8'h00) && ((r_sel & (r_sel - 8'h01)) == 8'h00);
    w_multi    = (r_sel != 8'h00) && !w_single;
    w_same     = w_single && (r_sel == r_last_sel) && (r_pat == r_last_pat);
    w_stab_nxt = w_same ? ((r_stab == STAB_MAX) ? r_stab : r_stab + SW'(1))
                        : (w_single ? SW'(1) : SW'(0));
    // a saturated dwell that already committed must not commit again
    w_commit   = (w_stab_nxt == STAB_MAX) && !(w_same && r_committed);
  end

  // one-hot anode to digit index
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < 8; i++)
      if (r_sel[i]) w_idx = 3'(i);
  end

  // glyph decode, abcdefg active-high
  always_comb begin
    w_legal = 1'b1;
    w_nib   = 4'h0;
    case (r_pat)
      7'b1111110: w_nib = 4'h0;
      7'b0110000: w_nib = 4'h1;
      7'b1101101: w_nib = 4'h2;
      7'b1111001: w_nib = 4'h3;
      7'b0110011: w_nib = 4'h4;
      7'b1011011: w_nib = 4'h5;
      7'b1011111: w_nib = 4'h6;
      7'b1110000: w_nib = 4'h7;
      7'b1111111: w_nib = 4'h8;
      7'b1111011: w_nib = 4'h9;
      7'b1110111: w_nib = 4'hA;
      7'b0011111: w_nib = 4'hB;
      7'b1001110: w_nib = 4'hC;
      7'b0111101: w_nib = 4'hD;
      7'b1001111: w_nib = 4'hE;
      7'b1000111: w_nib = 4'hF;
      default:    w_legal = 1'b0;
    endcase
    w_seen_nxt = r_seen | (8'h01 << w_idx);
  end

  // dwell tracker: remember the current candidate and how long it has held
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_pat  <= '0;
      r_last_sel  <= '0;
      r_stab      <= '0;
      r_committed <= 1'b0;
    end else begin
      r_stab <= w_stab_nxt;
      if (w_same) begin
        r_committed <= r_committed | w_commit;
      end else begin
        r_last_pat  <= r_pat;
        r_last_sel  <= r_sel;
        r_committed <= 1'b0;
      end
    end
  end

  // digit store, frame tracking and overlap pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_digits  <= '0;
      r_valid   <= '0;
      r_err     <= '0;
      r_seen    <= '0;
      r_overlap <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_overlap <= w_multi;
      r_frame   <= 1'b0;
      if (w_commit) begin
        if (w_legal) begin
          r_digits[{w_idx, 2'b00} +: 4] <= w_nib;
          r_valid[w_idx] <= 1'b1;
          r_err[w_idx]   <= 1'b0;
        end else if (r_pat == 7'b0000000) begin
          r_digits[{w_idx, 2'b00} +: 4] <= 4'h0;
          r_valid[w_idx] <= 1'b0;
          r_err[w_idx]   <= 1'b0;
        end else begin
          r_valid[w_idx] <= 1'b0;
          r_err[w_idx]   <= 1'b1;
        end
        if (w_seen_nxt == 8'hFF) begin
          r_frame <= 1'b1;
          r_seen  <= '0;
        end else begin
          r_seen  <= w_seen_nxt;
        end
      end else if (w_expire) begin
        // a stalled scan invalidates the digits but keeps their values
        r_valid <= '0;
        r_seen  <= '0;
      end
    end
  end

`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle;
  logic          r_stale;

  // expiry fires once, on the cycle the idle count reaches TIMEOUT
  assign w_expire = !w_commit && (r_idle == TW'(TIMEOUT - 1));

  // idle watchdog; a commit always beats expiry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idle  <= '0;
      r_stale <= 1'b0;
    end else if (w_commit) begin
      r_idle  <= '0;
      r_stale <= 1'b0;
    end else if (r_idle != TW'(TIMEOUT)) begin
      r_idle <= r_idle + TW'(1);
      if (w_expire) r_stale <= 1'b1;
    end
  end
  assign stale = r_stale;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |32'(TIMEOUT);
  assign w_expire = 1'b0;
  assign stale    = 1'b0;
`endif

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign digit_err   = r_err;
  assign overlap     = r_overlap;
  assign frame_done  = r_frame;
endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side counterpart of the multiplexed 7-segment driver. The block samples the scanned `segments`/`anodos` bus and decodes each digit's segment pattern back to a hex nibble. It holds the eight recovered digits in registers and flags illegal patterns, anode overlap and stalled scanning. It sits in loopback/self-check builds beside the display driver, on the same clock, so a driver can be checked in hardware or in simulation without a human reading the LEDs.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical samples needed before a digit is committed (≥2).
- `TIMEOUT`, default 1000000: clock cycles without any commit before captured digits are declared stale.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `segments` in 7: {CA,CB,CC,CD,CE,CF,CG}, active-low, as produced by the driver.
- `anodos` in 8: {AN7..AN0}, active-low digit enables.
- `digits` out 32: digit i in bits [4i+3:4i].
- `digit_valid` out 8: bit i = digit i holds a legal hex glyph.
- `digit_err` out 8: bit i = last pattern committed for digit i was illegal (non-hex, non-blank).
- `overlap` out 1: one-cycle pulse per sample with more than one anode active.
- `frame_done` out 1: one-cycle pulse when all eight digits have been committed since the last pulse.
- `stale` out 1: level; high once the timeout expires, cleared by the next commit.

## Operation
- Input stage: `segments`/`anodos` are registered once per cycle and inverted to active-high (`pat[6:0]` = {a..g}, `sel[7:0]`).
- Sample classes:
  - none (`sel`=0): idle.
  - single (one-hot): carries a candidate pair (idx, pat).
  - multi (≥2 bits set): `overlap` pulses.
- Dwell tracking:
  - Registers `last_idx`, `last_pat`, `stab_cnt`, `committed`.
  - A single sample equal to (last_idx, last_pat) increments `stab_cnt`, saturating at STABLE_CYCLES.
  - Any other sample loads `last_*`, sets `stab_cnt`=1 for a single sample or 0 otherwise, and clears `committed`.
- Commit: when `stab_cnt`==STABLE_CYCLES and `committed`=0, the block commits once per dwell and sets `committed`.
- Decode, active-high abcdefg → nibble:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, b:0011111, C:1001110, d:0111101, E:1001111, F:1000111
- Commit effect on digit idx:
  - Legal glyph: nibble written, valid=1, err=0.
  - Blank (0000000): nibble=0, valid=0, err=0.
  - Any other pattern: nibble unchanged, valid=0, err=1.
- Frame tracking:
  - `seen[idx]` is set on every commit.
  - When a commit makes `seen`=8'hFF, `frame_done` pulses and `seen` is cleared to 0 in that same update. A commit to an already-seen digit does not complete a frame.
- Timeout:
  - `idle_cnt` counts cycles since the last commit.
  - At TIMEOUT, `stale`=1, `digit_valid`=0 and `seen`=0. `digits` and `digit_err` are retained.
  - A commit clears `idle_cnt` and `stale` in the same update.
- Reset (any time, including mid-dwell): all state returns to reset values; a partial dwell is discarded.

## Timing
- Reset values:
  - Outputs: `digits`=0, `digit_valid`=0, `digit_err`=0, `overlap`=0, `frame_done`=0, `stale`=0.
  - Internal: `stab_cnt`=0, `seen`=0, `idle_cnt`=0.
- Commit latency: with input constant from before edge 1, sample k is captured at edge k and outputs update at edge STABLE_CYCLES+1 (5 with the default).
- `overlap` is asserted the cycle after the multi-anode sample is registered.
- `frame_done` is asserted in the same cycle as the completing digit's output update.
- Simultaneous commit and timeout expiry: the commit wins; `stale` stays 0 and the counter restarts.

## Configuration
- `SEG_CAPTURE_TIMEOUT_EN` defined: `idle_cnt` and the timeout behaviour are compiled in.
- Not defined:
  - No counter is built and `stale` is tied to 0.
  - `digit_valid` and `seen` are changed only by commits and reset.

## Test plan
- Hold `anodos`=8'hFE with `segments` for "3" (7'b0000110) for 5 cycles → `digits[3:0]`=3 and `digit_valid[0]`=1 at edge 5; no change at edge 4.
- Scan 8 digits "0123ABCD" (AN0 holds 0 … AN7 holds D), 10 cycles each → `digits`=32'hDCBA3210, `digit_valid`=8'hFF, single `frame_done` pulse on the AN7 commit.
- AN2 with pattern 7'b0110110 (illegal) for 6 cycles → `digit_err[2]`=1, `digit_valid[2]`=0, `digits[11:8]` unchanged.
- `anodos`=8'hFC for 1 cycle → `overlap` pulses once; a dwell of length 3 then change → no commit.
- `TIMEOUT`=50 with the macro defined, commit one digit, then drive 8'hFF for 60 cycles → `stale`=1 and `digit_valid`=0 after 50 cycles; next commit → `stale`=0. Macro undefined → `stale` stays 0.
- Assert `reset` low at stab_cnt=3 → all outputs 0; release and hold the pattern → commit occurs 5 edges after release.
